toggle_stim_gen: RTL
====================

Name: toggle_stim_gen

Overview:
- Clocked stimulus source that drives the input of the inverter cell under test.
- Produces a programmable, bounded train of level toggles with a fixed half-period.
- Replaces hand-written `#delay` toggle sequences in benches with a synthesizable, cycle-exact generator.
- Provides a start/busy/done handshake so a controller or checker downstream can sequence runs.

Parameters:
- CNT_W, 16, width of toggle-count input and remaining-count output
- DIV_W, 16, width of half-period input (cycles between toggles)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a run; sampled only in IDLE
- abort  input  1  terminate current run
- half_period  input  DIV_W  cycles between toggles; latched on accepted start
- num_toggles  input  CNT_W  number of toggles; latched on accepted start
- init_level  input  1  output level at run start
- out  output  1  stimulus bit, connects to the inverter input
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse on normal completion
- toggles_left  output  CNT_W  remaining toggles in the current or last run

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out=0, busy=0, done=0, toggles_left=0, divider=0.
  - Applies immediately, including mid-run; no done pulse.
- Outputs: busy and done are Moore decodes of the registered state. out and toggles_left are registers.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Accepted start (start=1, abort=0) latches hp=max(half_period,1) and N=num_toggles.
  - Same edge: out<=init_level, toggles_left<=N, divider<=0.
  - N!=0 goes to RUN; N==0 goes to DONE.
  - start with abort=1 is ignored.
- RUN:
  - Divider counts 0..hp-1.
  - At the edge where divider==hp-1: out<=~out, toggles_left<=toggles_left-1, divider<=0.
  - If that decrement reaches 0, go to DONE.
- RUN timing:
  - Start sampled at edge E0.
  - Toggles occur at edges E(k*hp), k=1..N.
  - DONE is entered at E(N*hp); done is high for exactly one cycle; IDLE is re-entered at E(N*hp+1).
- DONE: unconditional return to IDLE. out holds its last level (init_level XOR N[0]).
- start while in RUN or DONE is ignored; no queueing.
- abort in RUN:
  - Next edge goes to IDLE; no toggle that edge, even if divider==hp-1.
  - out and toggles_left hold; no done pulse.
  - abort in IDLE or DONE has no effect.
- toggles_left never underflows. hp and N inputs changing mid-run have no effect.

Optional Feature:
- Macro: TOGGLE_STIM_GEN_LFSR_EN.
- Defined:
  - Adds input mode_rand (1 bit), latched on accepted start.
  - When latched high, each tick loads out<=lfsr[0] instead of inverting out; the counting and FSM are unchanged.
  - LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts once per tick.
  - LFSR seed 16'hACE1, loaded on reset and on every accepted start.
- Undefined: no mode_rand port, no LFSR logic; behaviour is plain toggling.

Decomposition:
- Package toggle_stim_gen_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - LFSR_SEED and LFSR_TAPS constants
  - the hp-zero clamp constant HP_MIN=1
- One sub-module, stim_tick_div: a DIV_W-bit divider with clear and enable that emits a one-cycle tick every hp cycles. The top FSM owns out and toggles_left.

Test Plan:
- hp=1, N=9, init=0 -> out=0 at E0, toggles every edge E1..E9, final out=1, done high only in cycle E9..E10, toggles_left=0.
- hp=10, N=4, init=1 -> toggles at E10,E20,E30,E40, final out=1, busy high E0..E40, done one cycle after E40.
- N=0, init=1 -> out=1, never toggles, busy never high, done pulses at E1.
- hp=10, N=8, abort asserted before E25 -> 2 toggles seen, out=init, toggles_left=6, no done; a new start then runs normally.
- half_period=0 -> treated as 1; start pulsed at E3 of a run -> ignored, run length unchanged; start with abort in IDLE -> no run.
- rst_n low mid-RUN, between edges -> out=0, busy=0, toggles_left=0 immediately; after release, state is IDLE and no done pulse is seen.

Source files
------------

// File: rtl/toggle_stim_gen_pkg.sv
// ---------------------------------------------------------------------------
// toggle_stim_gen_pkg
// Shared definitions for the toggle stimulus generator:
//   - state_e      : FSM state encoding (IDLE / RUN / DONE)
//   - LFSR_SEED    : seed for the optional pseudo-random level source
//   - LFSR_TAPS    : feedback mask, x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   - HP_MIN       : clamp value for a zero half-period
//   - lfsr_next()  : one Fibonacci shift step (shift left, feedback into bit 0)
// ---------------------------------------------------------------------------
package toggle_stim_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          HP_MIN    = 1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/toggle_stim_gen_if.sv
// ---------------------------------------------------------------------------
// toggle_stim_gen_if
// Control/status bundle of the toggle stimulus generator.
//   master : the sequencer (drives start/abort/run config, reads status)
//   slave  : the generator
// Signals:
//   start, abort              run request / termination
//   half_period [DIV_W]       cycles between toggles (0 treated as 1)
//   num_toggles [CNT_W]       toggles in the run
//   init_level                out level at run start
//   mode_rand                 (TOGGLE_STIM_GEN_LFSR_EN only) random levels
//   out, busy, done           stimulus bit and run status
//   toggles_left [CNT_W]      remaining toggles of current/last run
// ---------------------------------------------------------------------------
interface toggle_stim_gen_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) ();

  logic             start;
  logic             abort;
  logic [DIV_W-1:0] half_period;
  logic [CNT_W-1:0] num_toggles;
  logic             init_level;
`ifdef TOGGLE_STIM_GEN_LFSR_EN
  logic             mode_rand;
`endif
  logic             out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] toggles_left;

  modport master (
`ifdef TOGGLE_STIM_GEN_LFSR_EN
    output mode_rand,
`endif
    output start, abort, half_period, num_toggles, init_level,
    input  out, busy, done, toggles_left
  );

  modport slave (
`ifdef TOGGLE_STIM_GEN_LFSR_EN
    input  mode_rand,
`endif
    input  start, abort, half_period, num_toggles, init_level,
    output out, busy, done, toggles_left
  );

endinterface

// File: rtl/toggle_stim_gen_tick_div.sv
// ---------------------------------------------------------------------------
// stim_tick_div
// Free-running divider that emits a one-cycle tick every i_hp enabled cycles.
// The count runs 0..i_hp-1; o_tick is high while enabled and the count sits
// at i_hp-1, and the count wraps to 0 on that same edge.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_clr        synchronous clear to 0 (dominates enable)
//   i_en         advance the count
//   i_hp         period in cycles, must be >= 1 (caller clamps)
//   o_tick       one-cycle tick
// ---------------------------------------------------------------------------
module stim_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_hp,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == (i_hp - DIV_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_en)   r_cnt <= o_tick ? '0 : r_cnt + DIV_W'(1);
  end

endmodule

// File: rtl/toggle_stim_gen.sv
// ---------------------------------------------------------------------------
// toggle_stim_gen
// Cycle-exact source of a bounded train of level toggles for the inverter
// cell under test. A start accepted in IDLE at edge E0 loads out=init_level;
// toggles then land on edges E(k*hp), k=1..N, DONE is held for one cycle
// after the last toggle, then IDLE. abort in RUN returns to IDLE on the next
// edge with out/toggles_left frozen and no done pulse.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          toggle_stim_gen_if.slave (start/abort/config in, status out)
// Build option:
//   TOGGLE_STIM_GEN_LFSR_EN  adds bus.mode_rand; when latched high each tick
//                            loads out from a 16-bit LFSR instead of inverting.
// ---------------------------------------------------------------------------
module toggle_stim_gen
  import toggle_stim_gen_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  toggle_stim_gen_if.slave  bus
);

  state_e           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_hp,    w_hp_nxt;
  logic             r_out,   w_out_nxt;
  logic [CNT_W-1:0] r_tl,    w_tl_nxt;

  logic w_accept;
  logic w_div_en;
  logic w_tick;
  logic w_tick_level;

  // start is only honoured in IDLE and only without a simultaneous abort
  assign w_accept = (r_state == IDLE) && bus.start && !bus.abort;

  // divider runs only in RUN; an abort clears it so no tick fires that edge
  assign w_div_en = (r_state == RUN) && !bus.abort;

  stim_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (!w_div_en),
    .i_en  (w_div_en),
    .i_hp  (r_hp),
    .o_tick(w_tick)
  );

`ifdef TOGGLE_STIM_GEN_LFSR_EN
  logic [15:0] r_lfsr;
  logic        r_rand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
      r_rand <= 1'b0;
    end else if (w_accept) begin
      r_lfsr <= LFSR_SEED;
      r_rand <= bus.mode_rand;
    end else if (w_tick) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_tick_level = r_rand ? r_lfsr[0] : ~r_out;
`else
  assign w_tick_level = ~r_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hp    <= '0;
      r_out   <= 1'b0;
      r_tl    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hp    <= w_hp_nxt;
      r_out   <= w_out_nxt;
      r_tl    <= w_tl_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hp_nxt    = r_hp;
    w_out_nxt   = r_out;
    w_tl_nxt    = r_tl;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_hp_nxt    = (bus.half_period == '0) ? DIV_W'(HP_MIN) : bus.half_period;
          w_out_nxt   = bus.init_level;
          w_tl_nxt    = bus.num_toggles;
          w_state_nxt = (bus.num_toggles != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else if (w_tick) begin
          // r_tl is >= 1 throughout RUN, so this cannot wrap
          w_out_nxt = w_tick_level;
          w_tl_nxt  = r_tl - CNT_W'(1);
          if (r_tl == CNT_W'(1)) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.out          = r_out;
  assign bus.busy         = (r_state == RUN);
  assign bus.done         = (r_state == DONE);
  assign bus.toggles_left = r_tl;

endmodule
